mem_bus_initiator: RTL

MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_cmd_fifo.sv | 61 ++++++
 rtl/mem_bus_initiator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: FSM encoding, command bundle and default sizes
// shared by the memory bus initiator and its command FIFO.
package mem_bus_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  function automatic logic is_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_bus_cmd_fifo.sv
// mem_bus_cmd_fifo: DEPTH-entry command queue (power of 2).
// Ports: clk, resetn, push_i/din_i, pop_i/dout_o, full_o, empty_o.
module mem_bus_cmd_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  cmd_t din_i,
  input  logic pop_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap for free because DEPTH is a power of 2.
  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: queues cmd_* requests, runs them one at a time on the
// mem_* bus with timeout/misalignment errors, returns results on rsp_*.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_instr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  cmd_t          in_cmd, head;
  cmd_t          cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          rdy_q;
  logic          full, empty;
  logic          push, pop;
  logic          tmo;

  // rdy_q holds cmd_ready low through reset and the first edge after it.
  assign cmd_ready = rdy_q && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign tmo       = cnt_q == CW'(TIMEOUT - 1);

  assign in_cmd = '{
    write: cmd_write,
    instr: cmd_instr,
    addr:  cmd_addr,
    wdata: cmd_wdata,
    wstrb: cmd_wstrb
  };

  mem_bus_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (push),
    .din_i  (in_cmd),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (!empty) begin
        cur_d       = head;
        cur_d.wstrb = head.write ? head.wstrb : 4'h0;
        cnt_d       = '0;
        rdata_d     = '0;
        err_d       = !is_aligned(head.addr);
        state_d     = is_aligned(head.addr) ? REQ : RESP;
      end
      REQ: if (mem_ready) begin
        rdata_d = cur_q.write ? '0 : mem_rdata;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = GAP;
      GAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = state_q == REQ;
    mem_instr = cur_q.instr;
    mem_addr  = cur_q.addr;
    mem_wdata = cur_q.wdata;
    mem_wstrb = cur_q.wstrb;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule
